// File: rtl/lbist_pkg.sv
// Shared LBIST definitions: controller state encoding, counter sizing and default tap masks.
package lbist_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPACT = 2'd1,
    CHECK   = 2'd2,
    DONE    = 2'd3
  } lbist_state_e;

  // Counter must hold the values 0..npat inclusive.
  function automatic int cnt_width(input int npat);
    return (npat < 1) ? 1 : $clog2(npat + 1);
  endfunction

  // Feedback tap masks shared by the pattern generator and the response analyser.
  function automatic logic [31:0] default_taps(input int width);
    case (width)
      2:       return 32'h0000_0003;
      3:       return 32'h0000_0003;
      4:       return 32'h0000_0003;
      5:       return 32'h0000_0005;
      6:       return 32'h0000_0003;
      7:       return 32'h0000_0003;
      8:       return 32'h0000_001D;
      16:      return 32'h0000_002D;
      32:      return 32'h0000_00C5;
      default: return 32'h0000_0003;
    endcase
  endfunction

endpackage

// File: rtl/misr_ora_if.sv
// Response/status bundle between the circuit-under-test side and the response analyser.
interface misr_ora_if
  import lbist_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int NPAT  = 15
);
  localparam int CW = cnt_width(NPAT);

  logic             start;
  logic             resp_valid;
  logic [WIDTH-1:0] resp;
  logic             busy;
  logic             done;
  logic             pass;
  logic [WIDTH-1:0] signature;
  logic [CW-1:0]    count;

  modport master (
    output start, resp_valid, resp,
    input  busy, done, pass, signature, count
  );

  modport slave (
    input  start, resp_valid, resp,
    output busy, done, pass, signature, count
  );

endinterface

// File: rtl/misr_core.sv
// Multiple-input signature register: shift toward bit 0, tap feedback into the MSB, XOR in din.
// One-cycle update when en is high; load (and rst) restore SEED and take priority over en.
module misr_core #(
  parameter int               WIDTH = 4,
  parameter logic [WIDTH-1:0] POLY  = 4'b0011,
  parameter logic [WIDTH-1:0] SEED  = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] sig
);

  logic             fb;
  logic [WIDTH-1:0] sig_next;

  always_comb begin
    fb       = ^(sig & POLY);
    sig_next = {fb ^ din[WIDTH-1], sig[WIDTH-1:1] ^ din[WIDTH-2:0]};
  end

  always_ff @(posedge clk) begin
    if (rst || load) begin
      sig <= SEED;
    end else if (en) begin
      sig <= sig_next;
    end
  end

endmodule

// File: rtl/misr_ora.sv
// LBIST output response analyser: compacts NPAT accepted beats, then compares against GOLDEN.
// done rises one edge after the CHECK state; no backpressure, beats outside COMPACT are dropped.
module misr_ora
  import lbist_pkg::*;
#(
  parameter int               WIDTH  = 4,
  parameter logic [WIDTH-1:0] POLY   = 4'b0011,
  parameter logic [WIDTH-1:0] SEED   = '0,
  parameter int               NPAT   = 15,
  parameter logic [WIDTH-1:0] GOLDEN = 4'h0
) (
  input  logic       clk,
  input  logic       rst,
  misr_ora_if.slave  bus
);

  localparam int CW = cnt_width(NPAT);

  localparam logic [1:0]    S_IDLE    = IDLE;
  localparam logic [1:0]    S_COMPACT = COMPACT;
  localparam logic [1:0]    S_CHECK   = CHECK;
  localparam logic [1:0]    S_DONE    = DONE;
  localparam logic [CW-1:0] LAST_CNT  = CW'(NPAT - 1);

  logic [1:0]       state;
  logic [CW-1:0]    count;
  logic             pass_q;
  logic [WIDTH-1:0] sig;
  logic             start_ok;
  logic             beat;

  assign start_ok = bus.start && ((state == S_IDLE) || (state == S_DONE));
  assign beat     = bus.resp_valid && (state == S_COMPACT);

  misr_core #(
    .WIDTH (WIDTH),
    .POLY  (POLY),
    .SEED  (SEED)
  ) u_core (
    .clk  (clk),
    .rst  (rst),
    .load (start_ok),
    .en   (beat),
    .din  (bus.resp),
    .sig  (sig)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      count  <= '0;
      pass_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            state <= S_COMPACT;
            count <= '0;
          end
        end
        S_COMPACT: begin
          // The beat that reaches NPAT also leaves COMPACT, so count never overshoots.
          if (bus.resp_valid) begin
            count <= count + 1'b1;
            if (count == LAST_CNT) begin
              state <= S_CHECK;
            end
          end
        end
        S_CHECK: begin
          pass_q <= (sig == GOLDEN);
          state  <= S_DONE;
        end
        S_DONE: begin
          if (bus.start) begin
            state  <= S_COMPACT;
            count  <= '0;
            pass_q <= 1'b0;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy      = (state == S_COMPACT) || (state == S_CHECK);
  assign bus.done      = (state == S_DONE);
  assign bus.pass      = pass_q;
  assign bus.signature = sig;
  assign bus.count     = count;

endmodule
